// File: rtl/axi_sub_arb_n_if.sv
// Request and component bundle for the N-way sub-bus arbiter.
// Latency: none, wires only.
// Backpressure: carries req_hld per channel and the component's hld.
interface axi_sub_arb_n_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int BC   = DW / 8,
  parameter int UW   = 32,
  parameter int IW   = 1,
  parameter int NREQ = 3
);
  // requestor side, channel i at [i*W +: W]
  logic [NREQ-1:0]      req_dv;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*UW-1:0]   req_user;
  logic [NREQ*IW-1:0]   req_id;
  logic [NREQ*3-1:0]    req_size;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ*BC-1:0]   req_wstrb;
  logic [NREQ-1:0]      req_hld;
  logic [NREQ-1:0]      req_err;
  logic [NREQ-1:0]      req_rvld;
  logic [DW-1:0]        req_rdata;

  // component side
  logic                 dv;
  logic                 write;
  logic [AW-1:0]        addr;
  logic [UW-1:0]        user;
  logic [IW-1:0]        id;
  logic [2:0]           size;
  logic                 last;
  logic [DW-1:0]        wdata;
  logic [BC-1:0]        wstrb;
  logic                 hld;
  logic                 rd_err;
  logic                 wr_err;
  logic [DW-1:0]        rdata;

  // arbiter view
  modport slave (
    input  req_dv, req_write, req_addr, req_user, req_id, req_size, req_last,
           req_wdata, req_wstrb,
    output req_hld, req_err, req_rvld, req_rdata,
    output dv, write, addr, user, id, size, last, wdata, wstrb,
    input  hld, rd_err, wr_err, rdata
  );

  // environment view (requestors plus component)
  modport master (
    output req_dv, req_write, req_addr, req_user, req_id, req_size, req_last,
           req_wdata, req_wstrb,
    input  req_hld, req_err, req_rvld, req_rdata,
    input  dv, write, addr, user, id, size, last, wdata, wstrb,
    output hld, rd_err, wr_err, rdata
  );
endinterface

// File: rtl/axi_sub_arb_n.sv
// Round-robin arbiter of NREQ requestor channels onto one sub-bus component.
// Latency: grant and request mux are combinational; read responses return C_LAT cycles after the read beat.
// Backpressure: component hld holds the winner, losers are always held; read return path never stalls.
// Option macro AXI_SUB_ARB_N_BURST_LOCK_EN: keep the grant on one channel from first to last beat.
module axi_sub_arb_n #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BC    = DW / 8,
  parameter int UW    = 32,
  parameter int IW    = 1,
  parameter int NREQ  = 3,
  parameter int C_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  axi_sub_arb_n_if.slave bus
);

  localparam int NW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NW-1:0] LAST_IDX = NW'(NREQ - 1);

  logic [NW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NW-1:0] search_idx;
  logic          search_hit;
  logic [NW-1:0] winner;
  logic [NW-1:0] owner;
  logic          locked;
  logic          dv_c;
  logic          acc;
  logic          acc_rd;
  logic          ptr_adv;
  logic          tail_vld;
  logic [NW-1:0] tail_idx;
  logic [NREQ-1:0] rvld_c;
  logic [NREQ-1:0] err_c;

  // first requesting channel at or after the round-robin pointer, wrapping
  always_comb begin
    search_idx = '0;
    search_hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!search_hit && bus.req_dv[(int'(rr_ptr_q) + k) % NREQ]) begin
        search_hit = 1'b1;
        search_idx = NW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign winner = locked ? owner : search_idx;
  // with no request the search falls back to channel 0, so its fields drive the component
  assign dv_c   = locked ? bus.req_dv[winner] : |bus.req_dv;
  assign acc    = dv_c & ~bus.hld;
  assign acc_rd = acc & ~bus.req_write[winner];

`ifdef AXI_SUB_ARB_N_BURST_LOCK_EN
  logic          lock_q, lock_d;
  logic [NW-1:0] owner_q, owner_d;

  // burst lock: pin the grant to the owner from its first accepted beat until its last
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (acc) begin
      if (bus.req_last[winner]) begin
        lock_d = 1'b0;
      end else begin
        lock_d  = 1'b1;
        owner_d = winner;
      end
    end
  end

  // lock/owner registers; reset abandons any burst in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end

  assign locked  = lock_q;
  assign owner   = owner_q;
  assign ptr_adv = acc & bus.req_last[winner];
`else
  assign locked  = 1'b0;
  assign owner   = '0;
  assign ptr_adv = acc;
`endif

  // pointer moves just past the channel that finished
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ptr_adv) begin
      rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + 1'b1;
    end
  end

  // round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // component request, muxed from the winner
  assign bus.dv    = dv_c;
  assign bus.write = bus.req_write[winner];
  assign bus.addr  = bus.req_addr[int'(winner) * AW +: AW];
  assign bus.user  = bus.req_user[int'(winner) * UW +: UW];
  assign bus.id    = bus.req_id[int'(winner) * IW +: IW];
  assign bus.size  = bus.req_size[int'(winner) * 3 +: 3];
  assign bus.last  = bus.req_last[winner];
  assign bus.wdata = bus.req_wdata[int'(winner) * DW +: DW];
  assign bus.wstrb = bus.req_wstrb[int'(winner) * BC +: BC];

  // only the requesting winner can pass, and only while the component is not holding
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_hld[i] = bus.hld || (winner != NW'(i)) || !bus.req_dv[i];
    end
  end

  generate
    if (C_LAT > 0) begin : g_rd_pipe
      logic [C_LAT-1:0] pv_q;
      logic [NW-1:0]    pidx_q [C_LAT];

      // read return tracker: shifts every cycle, hld does not stall returning data
      always_ff @(posedge clk) begin
        if (rst) begin
          pv_q <= '0;
          for (int s = 0; s < C_LAT; s++) begin
            pidx_q[s] <= '0;
          end
        end else begin
          pv_q[0]   <= acc_rd;
          pidx_q[0] <= winner;
          for (int s = 1; s < C_LAT; s++) begin
            pv_q[s]   <= pv_q[s-1];
            pidx_q[s] <= pidx_q[s-1];
          end
        end
      end

      assign tail_vld = pv_q[C_LAT-1];
      assign tail_idx = pidx_q[C_LAT-1];
    end else begin : g_rd_comb
      // zero-latency component: the response belongs to this cycle's read beat
      assign tail_vld = acc_rd;
      assign tail_idx = winner;
    end
  endgenerate

  // response and error routing; write and read errors to one channel merge
  always_comb begin
    rvld_c = '0;
    err_c  = '0;
    if (acc && bus.req_write[winner]) begin
      err_c[winner] = bus.wr_err;
    end
    if (tail_vld) begin
      rvld_c[tail_idx] = 1'b1;
      err_c[tail_idx]  = err_c[tail_idx] | bus.rd_err;
    end
    if (rst) begin
      rvld_c = '0;
      err_c  = '0;
    end
  end

  assign bus.req_rvld  = rvld_c;
  assign bus.req_err   = err_c;
  assign bus.req_rdata = bus.rdata;

endmodule

// File: doc/axi_sub_arb_n.md
AXI_SUB_ARB_N -- requirements
Module: axi_sub_arb_n

Interface
REQ-001: Parameters (name, default, meaning), one per line:
  AW 32 byte-address width; DW 32 data width; BC = DW/8 strobe width; UW 32 user width; IW 1 ID width.
  NREQ 3 requestor channel count (2..8); NW = $clog2(NREQ) index width.
  C_LAT 0 component read latency (dv && !hld -> rdata, 0..4).
REQ-002: The block SHALL have one clock and a synchronous, active-high reset. Ports (name, direction, width, meaning), one per line:
  clk  in  1  clock.
  rst  in  1  synchronous active-high reset.
  req_dv  in  NREQ  per-channel beat valid.
  req_write  in  NREQ  1 = write beat.
  req_addr  in  NREQ*AW  byte address, channel i at [i*AW +: AW].
  req_user  in  NREQ*UW  user field.
  req_id  in  NREQ*IW  transaction ID.
  req_size  in  NREQ*3  beat size.
  req_last  in  NREQ  final beat of burst.
  req_wdata  in  NREQ*DW  write data.
  req_wstrb  in  NREQ*BC  write strobes.
  req_hld  out  NREQ  per-channel hold.
  req_err  out  NREQ  per-channel error.
  req_rvld  out  NREQ  read data valid for channel i.
  req_rdata  out  DW  read data, broadcast to all channels.
  dv, write, addr, user, id, size, last, wdata, wstrb  out  1/1/AW/UW/IW/3/1/DW/BC  component request, muxed from the winner.
  hld  in  1  component hold.
  rd_err  in  1  read error, aligned with rdata.
  wr_err  in  1  write error, aligned with dv.
  rdata  in  DW  component read data.

Function
REQ-003: Beat acceptance: channel i's beat is accepted when req_dv[i] && !req_hld[i].
REQ-004: Arbitration: round-robin pointer rr_ptr (NW bits). Winner = first channel with req_dv set, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
REQ-005: Burst lock: a lock flag and owner index are held in registers.
  - Accepted non-last beat: set lock, set owner to the winner.
  - Accepted last beat: clear lock.
  - While locked, the winner is the owner, regardless of the other channels' dv.
REQ-006: Pointer update: on an accepted last beat, rr_ptr <= (winner == NREQ-1) ? 0 : winner+1. The pointer does not change otherwise.
REQ-007: dv = req_dv[winner] when locked, else OR of req_dv. All component outputs SHALL be muxed from the winner's fields. With no request, the outputs SHALL be channel 0's fields.
REQ-008: req_hld[i] = hld || (i != winner) || !req_dv[i].
  - At most one channel SHALL be accepted per cycle.
REQ-009: Write error: req_err[i] = wr_err for the winner when its beat is a write.
REQ-010: Read response routing, C_LAT > 0:
  - Each accepted read beat pushes {valid, winner} into a C_LAT-deep shift pipeline.
  - The pipeline advances every cycle; hld does not stall it.
  - At the pipeline tail: req_rvld[tail_idx] = tail_valid, and req_err[tail_idx] |= rd_err & tail_valid.
REQ-011: Read response routing, C_LAT = 0: req_rvld[winner] and the rd_err route are asserted combinationally in the cycle of the accepted read beat. No pipeline is instantiated.
REQ-012: Write and read error routes targeting the same channel in the same cycle SHALL be ORed.
REQ-013: req_rdata = rdata, unconditionally.
REQ-014: Single-channel request (only req_dv[k] set, unlocked): channel k wins in the same cycle, with zero added latency.
REQ-015: Owner drops dv mid-burst while locked: dv = 0, the lock holds, and no other channel is granted.
REQ-016: Simultaneous last-beat acceptance and a new request: the new arbitration takes effect the following cycle using the updated rr_ptr.

Reset
REQ-017: While rst is high at a clk edge:
  - Register values: rr_ptr = 0, lock = 0, owner = 0, read pipeline valid bits = 0.
  - Outputs: dv = 0 when all req_dv are 0, req_rvld = 0, req_err = 0.
REQ-018: Reset asserted mid-burst or with reads in flight SHALL abandon the lock and drop all pending read responses. No req_rvld SHALL assert for beats issued before reset.

Configuration
REQ-019: Macro AXI_SUB_ARB_N_BURST_LOCK_EN, defined: REQ-005 and REQ-015 apply.
REQ-020: Macro AXI_SUB_ARB_N_BURST_LOCK_EN, undefined:
  - The lock/owner registers are absent, and arbitration is re-evaluated every beat per REQ-004.
  - rr_ptr updates on every accepted beat, last or not.

Verification
REQ-021: Configuration for all scenarios: NREQ=3, C_LAT=1, lock enabled. Reset, then req_dv=3'b111 with 1-beat bursts and hld=0 -> grants 0,1,2,0 on consecutive cycles.
REQ-022: Channel 1 starts a 4-beat write, and channel 0 requests at beat 2 -> channel 1 completes all 4 beats uninterrupted, then channel 0 is granted; the req_hld[0] count equals 3.
REQ-023: Channel 2 read is accepted with rdata=32'hA5A5_0001 returned 1 cycle later, with hld=1 for 2 cycles in between on a channel 0 request -> req_rvld=3'b100 exactly once, with the correct data.
REQ-024: Channel 0 write with wr_err=1, and rd_err=1 on the response of an outstanding channel 1 read in the same cycle -> req_err=3'b011.
REQ-025: rst asserted during beat 2 of a channel 1 burst with 1 read in flight -> the next cycle rr_ptr=0, no lock, req_rvld=0; channel 0 wins the next 3-way request.
REQ-026: Lock disabled, channels 0 and 1 both issuing 2-beat bursts -> beats interleave 0,1,0,1.
